// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// with a single registered response slot that reloads on the drain cycle.

package alu_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;
endpackage

module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  alu_pkg::alu_op_e      i_op,
  output logic [DATA_WIDTH-1:0] o_y
);
  // ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow is produced.
  always_comb begin
    o_y = '0;
    unique case (i_op)
      alu_pkg::OP_ADD: o_y = i_a + i_b;
      alu_pkg::OP_SUB: o_y = i_a - i_b;
      alu_pkg::OP_AND: o_y = i_a & i_b;
      alu_pkg::OP_OR:  o_y = i_a | i_b;
      default:         o_y = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_REQ-1:0]                   i_req_valid,
  output logic [NUM_REQ-1:0]                   o_req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_b,
  input  alu_pkg::alu_op_e [NUM_REQ-1:0]       i_req_op,
  output logic                                 o_rsp_valid,
  input  logic                                 i_rsp_ready,
  output logic [ID_WIDTH-1:0]                  o_rsp_id,
  output logic [DATA_WIDTH-1:0]                o_rsp_data
);

  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [ID_WIDTH-1:0]   r_rr_ptr;

  logic                  w_slot_free;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_grant_idx;
  logic [ID_WIDTH-1:0]   w_next_ptr;
  logic                  w_accept;
  int                    w_scan_idx;

  logic [DATA_WIDTH-1:0] w_alu_a;
  logic [DATA_WIDTH-1:0] w_alu_b;
  alu_pkg::alu_op_e      w_alu_op;
  logic [DATA_WIDTH-1:0] w_alu_y;

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;

  // Scan from the highest offset down so the lowest offset from r_rr_ptr wins.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_scan_idx  = 0;
    if (i_rst_n && w_slot_free) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        w_scan_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
        if (i_req_valid[w_scan_idx]) begin
          w_grant              = '0;
          w_grant[w_scan_idx]  = 1'b1;
          w_grant_idx          = ID_WIDTH'(w_scan_idx);
        end
      end
    end
  end

  assign w_accept   = |(w_grant & i_req_valid);
  assign w_next_ptr = (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : w_grant_idx + ID_WIDTH'(1);

  assign w_alu_a  = i_req_a[w_grant_idx];
  assign w_alu_b  = i_req_b[w_grant_idx];
  assign w_alu_op = i_req_op[w_grant_idx];

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_a  (w_alu_a),
    .i_b  (w_alu_b),
    .i_op (w_alu_op),
    .o_y  (w_alu_y)
  );

  // An accept takes priority over a drain, so a drain+accept cycle reloads the slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_idx;
      r_rsp_data  <= w_alu_y;
      r_rr_ptr    <= w_next_ptr;
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

endmodule
